// File: rtl/memoria_pkg.sv
// Shared definitions for the memoria arbiter: FSM encoding, requester ids and
// default memory geometry.
package memoria_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin picker; the last-winner pointer lives in the parent.
module arbitro_rr2
    import memoria_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_ultimo,
    output logic o_winner_c,
    output logic o_any_c
);

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        o_any_c    = i_req_a | i_req_b;
        o_winner_c = REQ_A;
        if (i_req_a && i_req_b) begin
            o_winner_c = ~i_ultimo;
        end else if (i_req_b) begin
            o_winner_c = REQ_B;
        end
    end

endmodule

// File: rtl/memoria.sv
// Simple dual-address memory: writes commit on the write-clock negedge, reads
// are registered on the read-clock posedge.
module memoria #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  write_clock,
    input  logic                  read_clock,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  EscMen,
    output logic [DATA_WIDTH-1:0] saida
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(negedge write_clock) begin
        if (EscMen) begin
            r_mem[write_addr] <= data;
        end
    end

    always_ff @(posedge read_clock) begin
        saida <= r_mem[read_addr];
    end

endmodule

// File: rtl/memoria_arbitro.sv
// Shares one memoria between requesters A and B: round-robin grant, one access
// at a time, registered read data returned with a valid strobe.
module memoria_arbitro
    import memoria_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_gnt,
    output logic                  a_valid,
    output logic [DATA_WIDTH-1:0] a_saida,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_gnt,
    output logic                  b_valid,
    output logic [DATA_WIDTH-1:0] b_saida,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    output logic                  mem_EscMen,
    input  logic [DATA_WIDTH-1:0] mem_saida
);

    estado_t               r_estado, w_estado_nxt;
    logic                  r_ultimo, w_ultimo_nxt;
    logic                  r_id, w_id_nxt;
    logic                  r_we, w_we_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
    logic                  r_a_gnt, w_a_gnt_nxt;
    logic                  r_b_gnt, w_b_gnt_nxt;
    logic                  r_a_valid, w_a_valid_nxt;
    logic                  r_b_valid, w_b_valid_nxt;
    logic                  r_esc, w_esc_nxt;
    logic [DATA_WIDTH-1:0] r_a_saida, w_a_saida_nxt;
    logic [DATA_WIDTH-1:0] r_b_saida, w_b_saida_nxt;
    logic                  w_winner;
    logic                  w_any;
    logic                  w_we_sel;

    arbitro_rr2 u_rr (
        .i_req_a    (a_req),
        .i_req_b    (b_req),
        .i_ultimo   (r_ultimo),
        .o_winner_c (w_winner),
        .o_any_c    (w_any)
    );

    assign w_we_sel = (w_winner == REQ_B) ? b_we : a_we;

    // Next-state and next-output logic; strobes are decoded one cycle early so
    // they come straight out of flops.
    always_comb begin
        w_estado_nxt  = r_estado;
        w_ultimo_nxt  = r_ultimo;
        w_id_nxt      = r_id;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_a_gnt_nxt   = 1'b0;
        w_b_gnt_nxt   = 1'b0;
        w_a_valid_nxt = 1'b0;
        w_b_valid_nxt = 1'b0;
        w_esc_nxt     = 1'b0;
        w_a_saida_nxt = r_a_saida;
        w_b_saida_nxt = r_b_saida;
        case (r_estado)
            OCIOSO: begin
                if (w_any) begin
                    w_estado_nxt = ACESSO;
                    w_id_nxt     = w_winner;
                    w_ultimo_nxt = w_winner;
                    w_we_nxt     = w_we_sel;
                    w_addr_nxt   = (w_winner == REQ_B) ? b_addr : a_addr;
                    w_data_nxt   = (w_winner == REQ_B) ? b_data : a_data;
                    w_a_gnt_nxt  = (w_winner == REQ_A);
                    w_b_gnt_nxt  = (w_winner == REQ_B);
                    w_esc_nxt    = w_we_sel;
                end
            end
            ACESSO: begin
                if (r_we) begin
                    w_estado_nxt = OCIOSO;
                end else begin
                    w_estado_nxt  = RESPOSTA;
                    w_a_valid_nxt = (r_id == REQ_A);
                    w_b_valid_nxt = (r_id == REQ_B);
                end
            end
            RESPOSTA: begin
                w_estado_nxt = OCIOSO;
                if (r_id == REQ_A) begin
                    w_a_saida_nxt = mem_saida;
                end else begin
                    w_b_saida_nxt = mem_saida;
                end
            end
            default: begin
                w_estado_nxt = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado  <= OCIOSO;
            r_ultimo  <= REQ_B;
            r_id      <= REQ_A;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_a_gnt   <= 1'b0;
            r_b_gnt   <= 1'b0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_esc     <= 1'b0;
            r_a_saida <= '0;
            r_b_saida <= '0;
        end else begin
            r_estado  <= w_estado_nxt;
            r_ultimo  <= w_ultimo_nxt;
            r_id      <= w_id_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_a_gnt   <= w_a_gnt_nxt;
            r_b_gnt   <= w_b_gnt_nxt;
            r_a_valid <= w_a_valid_nxt;
            r_b_valid <= w_b_valid_nxt;
            r_esc     <= w_esc_nxt;
            r_a_saida <= w_a_saida_nxt;
            r_b_saida <= w_b_saida_nxt;
        end
    end

    assign a_gnt          = r_a_gnt;
    assign b_gnt          = r_b_gnt;
    assign a_valid        = r_a_valid;
    assign b_valid        = r_b_valid;
    assign mem_EscMen     = r_esc;
    assign mem_data       = r_data;
    assign mem_write_addr = r_addr;
    assign mem_read_addr  = r_addr;

    // Read data flows through during the valid cycle, then is held.
    assign a_saida = r_a_valid ? mem_saida : r_a_saida;
    assign b_saida = r_b_valid ? mem_saida : r_b_saida;

endmodule

// File: tb/tb_memoria_arbitro.sv
// Directed bench for memoria_arbitro driving a real memoria instance.
module tb_memoria_arbitro;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       a_req = 1'b0, a_we = 1'b0;
    logic [5:0] a_addr = '0;
    logic [7:0] a_data = '0;
    logic       b_req = 1'b0, b_we = 1'b0;
    logic [5:0] b_addr = '0;
    logic [7:0] b_data = '0;
    logic       a_gnt, a_valid, b_gnt, b_valid, mem_EscMen;
    logic [7:0] a_saida, b_saida, mem_data, mem_saida;
    logic [5:0] mem_write_addr, mem_read_addr;

    int n_pass  = 0;
    int n_total = 0;
    int na, nb;

    always #5 clock = ~clock;

    memoria_arbitro #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
        .a_gnt(a_gnt), .a_valid(a_valid), .a_saida(a_saida),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .b_gnt(b_gnt), .b_valid(b_valid), .b_saida(b_saida),
        .mem_data(mem_data), .mem_write_addr(mem_write_addr),
        .mem_read_addr(mem_read_addr), .mem_EscMen(mem_EscMen),
        .mem_saida(mem_saida)
    );

    memoria #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) u_mem (
        .write_clock(clock), .read_clock(clock),
        .data(mem_data), .write_addr(mem_write_addr),
        .read_addr(mem_read_addr), .EscMen(mem_EscMen), .saida(mem_saida)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_a_gnt"}, 32'(a_gnt), 0);
        check({tag, "_b_gnt"}, 32'(b_gnt), 0);
        check({tag, "_a_valid"}, 32'(a_valid), 0);
        check({tag, "_b_valid"}, 32'(b_valid), 0);
        check({tag, "_esc"}, 32'(mem_EscMen), 0);
    endtask

    task automatic drive(input bit side, input bit req, input bit we,
                         input logic [5:0] addr, input logic [7:0] data);
        if (!side) begin
            a_req = req; a_we = we; a_addr = addr; a_data = data;
        end else begin
            b_req = req; b_we = we; b_addr = addr; b_data = data;
        end
    endtask

    task automatic do_write(input bit side, input logic [5:0] addr,
                            input logic [7:0] data, input string tag);
        drive(side, 1'b1, 1'b1, addr, data);
        tick();
        check({tag, "_gnt"}, 32'(side ? b_gnt : a_gnt), 1);
        check({tag, "_other_gnt"}, 32'(side ? a_gnt : b_gnt), 0);
        check({tag, "_esc"}, 32'(mem_EscMen), 1);
        check({tag, "_waddr"}, 32'(mem_write_addr), 32'(addr));
        check({tag, "_wdata"}, 32'(mem_data), 32'(data));
        drive(side, 1'b0, 1'b0, 6'h00, 8'h00);
        tick();
        check_quiet({tag, "_after"});
    endtask

    task automatic do_read(input bit side, input logic [5:0] addr,
                           input logic [7:0] exp, input string tag);
        drive(side, 1'b1, 1'b0, addr, 8'h00);
        tick();
        check({tag, "_gnt"}, 32'(side ? b_gnt : a_gnt), 1);
        check({tag, "_esc"}, 32'(mem_EscMen), 0);
        drive(side, 1'b0, 1'b0, 6'h00, 8'h00);
        tick();
        check({tag, "_valid"}, 32'(side ? b_valid : a_valid), 1);
        check({tag, "_other_valid"}, 32'(side ? a_valid : b_valid), 0);
        check({tag, "_saida"}, 32'(side ? b_saida : a_saida), 32'(exp));
        tick();
        check({tag, "_valid_drop"}, 32'(side ? b_valid : a_valid), 0);
        check({tag, "_saida_hold"}, 32'(side ? b_saida : a_saida), 32'(exp));
    endtask

    initial begin
        // Asynchronous reset before any clock edge.
        #1 reset = 1'b1;
        #1;
        check_quiet("rst");
        check("rst_a_saida", 32'(a_saida), 0);
        check("rst_b_saida", 32'(b_saida), 0);
        check("rst_waddr", 32'(mem_write_addr), 0);
        check("rst_wdata", 32'(mem_data), 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_quiet("idle");

        do_write(1'b0, 6'h12, 8'h5A, "a_wr12");
        do_read(1'b0, 6'h12, 8'h5A, "a_rd12");

        do_write(1'b0, 6'h01, 8'h11, "pre_a");
        do_write(1'b1, 6'h02, 8'h22, "pre_b");

        // Reset pulse so the round-robin pointer starts fresh.
        reset = 1'b1;
        #2 reset = 1'b0;
        tick();

        // Simultaneous reads: A wins the first tie.
        drive(1'b0, 1'b1, 1'b0, 6'h01, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 6'h02, 8'h00);
        tick();
        check("sim_a_gnt", 32'(a_gnt), 1);
        check("sim_b_gnt0", 32'(b_gnt), 0);
        drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
        tick();
        check("sim_a_valid", 32'(a_valid), 1);
        check("sim_b_valid0", 32'(b_valid), 0);
        check("sim_a_saida", 32'(a_saida), 32'h11);
        check("sim_gnts_resp", 32'({a_gnt, b_gnt}), 0);
        tick();
        check_quiet("sim_gap");
        tick();
        check("sim_b_gnt", 32'(b_gnt), 1);
        check("sim_a_gnt0", 32'(a_gnt), 0);
        drive(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        tick();
        check("sim_b_valid", 32'(b_valid), 1);
        check("sim_a_valid0", 32'(a_valid), 0);
        check("sim_b_saida", 32'(b_saida), 32'h22);
        check("sim_a_hold", 32'(a_saida), 32'h11);
        tick();
        check_quiet("sim_end");

        // Fairness: both hold write requests for 40 cycles.
        drive(1'b0, 1'b1, 1'b1, 6'h30, 8'hA0);
        drive(1'b1, 1'b1, 1'b1, 6'h31, 8'hB0);
        na = 0;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            check("fair_a_gnt", 32'(a_gnt), 32'(c % 4 == 0));
            check("fair_b_gnt", 32'(b_gnt), 32'(c % 4 == 2));
            if (a_gnt) na++;
            if (b_gnt) nb++;
            if (c == 38) begin
                drive(1'b0, 1'b0, 1'b0, 6'h00, 8'h00);
                drive(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
            end
        end
        check("fair_na", 32'(na), 10);
        check("fair_nb", 32'(nb), 10);
        tick();
        check_quiet("fair_end");

        // Address extremes and data extremes.
        do_write(1'b0, 6'h3F, 8'hFF, "wr3f");
        do_write(1'b1, 6'h00, 8'h00, "wr00");
        do_read(1'b0, 6'h3F, 8'hFF, "rd3f");
        do_read(1'b1, 6'h00, 8'h00, "rd00");
        do_read(1'b0, 6'h31, 8'hB0, "rd31");
        do_read(1'b1, 6'h30, 8'hA0, "rd30");

        // Reset during an in-flight B read.
        drive(1'b1, 1'b1, 1'b0, 6'h02, 8'h00);
        tick();
        check("rr_b_gnt", 32'(b_gnt), 1);
        drive(1'b1, 1'b0, 1'b0, 6'h00, 8'h00);
        #2 reset = 1'b1;
        #1;
        check("rr_b_gnt_async", 32'(b_gnt), 0);
        check("rr_esc_async", 32'(mem_EscMen), 0);
        tick();
        check("rr_b_valid1", 32'(b_valid), 0);
        reset = 1'b0;
        tick();
        check("rr_b_valid2", 32'(b_valid), 0);
        check_quiet("rr_idle");
        do_read(1'b0, 6'h12, 8'h5A, "rr_a_rd12");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
